// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: address width,
// reset vector, sequential increment and the redirect-target helpers.
package pc_pkg;

    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_VECTOR = 64'h0000_0000_0000_0000;
    localparam addr_t INSN_BYTES   = 64'h0000_0000_0000_0004;

    // Clears the two low bits of a redirect target.
    localparam addr_t ALIGN_MASK   = {{(XLEN-2){1'b1}}, 2'b00};

    // Redirect targets are loaded word-aligned: low two bits forced to zero.
    function automatic addr_t align_target(input addr_t target);
        return target & ALIGN_MASK;
    endfunction

    // True when a redirect target is not word-aligned.
    function automatic logic is_misaligned(input addr_t target);
        return ((target & ~ALIGN_MASK) != {XLEN{1'b0}});
    endfunction

endpackage

// File: rtl/pc_plus_4.sv
// Sequential-address adder: next_pc = pc + INSN_BYTES, modulo 2^XLEN.
// Purely combinational; the carry out of the top bit is dropped, so
// 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
module pc_plus_4
    import pc_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc
);

    // Fixed-increment add; the result is truncated to XLEN bits.
    always_comb begin
        next_pc = pc + INSN_BYTES;
    end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter: holds the current instruction address,
// exposes pc+4, and on each enabled clock loads either the sequential
// address or a word-aligned redirect target. Reset is asynchronous and
// active-low and forces RESET_VECTOR immediately.
module program_counter_unit
    import pc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_en,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4,
    output logic            target_misalign
);

    addr_t pc_q;
    addr_t pc_d;
    addr_t seq_pc_s;
    logic  misalign_s;

    // The adder is shared: it drives both the pc_plus_4 output and the
    // sequential leg of the next-PC mux.
    pc_plus_4 u_pc_plus_4 (
        .pc      (pc_q),
        .next_pc (seq_pc_s)
    );

    // Next-PC selection: a stall holds even when a redirect is requested.
    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            if (pc_src) begin
                pc_d = align_target(branch_target);
            end else begin
                pc_d = seq_pc_s;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // Misalignment flag is informational only and never gates the load.
    always_comb begin
        misalign_s = 1'b0;
        if (pc_src) begin
            misalign_s = is_misaligned(branch_target);
        end else begin
            misalign_s = 1'b0;
        end
    end

    // PC register; reset assertion discards any update in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc              = pc_q;
    assign pc_plus_4       = seq_pc_s;
    assign target_misalign = misalign_s;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed, table-driven bench for program_counter_unit plus a standalone
// check of the pc_plus_4 adder.
module tb_program_counter_unit;
    import pc_pkg::*;

    logic  clk;
    logic  rst;
    logic  pc_en;
    logic  pc_src;
    addr_t branch_target;
    addr_t pc;
    addr_t pc_p4;
    logic  target_misalign;

    addr_t add_in;
    addr_t add_out;

    int n_tests;
    int n_fail;

    program_counter_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc_en           (pc_en),
        .pc_src          (pc_src),
        .branch_target   (branch_target),
        .pc              (pc),
        .pc_plus_4       (pc_p4),
        .target_misalign (target_misalign)
    );

    pc_plus_4 u_adder (
        .pc      (add_in),
        .next_pc (add_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  en;
        logic  src;
        addr_t target;
        logic  exp_mis;
        addr_t exp_pc;
    } vec_t;

    typedef struct {
        addr_t a;
        addr_t y;
    } add_vec_t;

    vec_t     vecs[15];
    add_vec_t avecs[6];

    task automatic check64(input string name, input addr_t got, input addr_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Main sequence: drive on negedge, check misalign before the edge,
        // check pc/pc_plus_4 just after the edge.
        vecs[0]  = '{1'b1, 1'b0, 64'h0,                  1'b0, 64'h4};
        vecs[1]  = '{1'b1, 1'b0, 64'h0,                  1'b0, 64'h8};
        vecs[2]  = '{1'b1, 1'b0, 64'h0,                  1'b0, 64'hC};
        vecs[3]  = '{1'b1, 1'b1, 64'h100,                1'b0, 64'h100};
        vecs[4]  = '{1'b1, 1'b0, 64'h0,                  1'b0, 64'h104};
        vecs[5]  = '{1'b0, 1'b0, 64'h0,                  1'b0, 64'h104};
        vecs[6]  = '{1'b0, 1'b0, 64'h0,                  1'b0, 64'h104};
        vecs[7]  = '{1'b1, 1'b0, 64'h0,                  1'b0, 64'h108};
        vecs[8]  = '{1'b1, 1'b1, 64'h10C,                1'b0, 64'h10C};
        vecs[9]  = '{1'b1, 1'b1, 64'h10E,                1'b1, 64'h10C};
        vecs[10] = '{1'b0, 1'b1, 64'h200,                1'b0, 64'h10C};
        vecs[11] = '{1'b0, 1'b1, 64'h203,                1'b1, 64'h10C};
        vecs[12] = '{1'b1, 1'b0, 64'h3,                  1'b0, 64'h110};
        vecs[13] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[14] = '{1'b1, 1'b0, 64'h0,                  1'b0, 64'h0};

        avecs[0] = '{64'h100,                  64'h104};
        avecs[1] = '{64'h0,                    64'h4};
        avecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC,  64'h0};
        avecs[3] = '{64'h1234_5678,            64'h1234_567C};
        avecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE,  64'h2};
        avecs[5] = '{64'h0000_0000_FFFF_FFFC,  64'h1_0000_0000};

        // Reset asserted from time zero; check before any clock edge.
        rst           = 1'b0;
        pc_en         = 1'b1;
        pc_src        = 1'b1;
        branch_target = 64'h5555_0000;
        add_in        = 64'h0;
        #1;
        check64("reset_pc_before_edge", pc, 64'h0);
        check64("reset_pc4_before_edge", pc_p4, 64'h4);

        // Clock toggles under reset with updates requested: pc stays put.
        repeat (3) @(posedge clk);
        #1;
        check64("reset_pc_after_edges", pc, 64'h0);
        check64("reset_pc4_after_edges", pc_p4, 64'h4);

        // Adder standalone.
        for (int i = 0; i < 6; i++) begin
            add_in = avecs[i].a;
            #1;
            check64($sformatf("adder[%0d]", i), add_out, avecs[i].y);
        end

        // Release reset between edges: release alone does not move pc.
        @(negedge clk);
        pc_en  = 1'b1;
        pc_src = 1'b0;
        rst    = 1'b1;
        #1;
        check64("release_no_change", pc, 64'h0);

        for (int i = 0; i < 15; i++) begin
            if (i != 0) @(negedge clk);
            pc_en         = vecs[i].en;
            pc_src        = vecs[i].src;
            branch_target = vecs[i].target;
            #1;
            check1($sformatf("misalign[%0d]", i), target_misalign, vecs[i].exp_mis);
            @(posedge clk);
            #1;
            check64($sformatf("pc[%0d]", i), pc, vecs[i].exp_pc);
            check64($sformatf("pc4[%0d]", i), pc_p4, vecs[i].exp_pc + 64'h4);
        end

        // Async reset mid-run: move to 0x10C, then drop rst between edges.
        @(negedge clk);
        pc_en         = 1'b1;
        pc_src        = 1'b1;
        branch_target = 64'h10C;
        @(posedge clk);
        #1;
        check64("pre_reset_pc", pc, 64'h10C);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check64("async_reset_pc", pc, 64'h0);
        check64("async_reset_pc4", pc_p4, 64'h4);
        @(posedge clk);
        #1;
        check64("reset_overrides_load", pc, 64'h0);

        @(negedge clk);
        rst    = 1'b1;
        pc_en  = 1'b1;
        pc_src = 1'b0;
        #1;
        check64("release2_no_change", pc, 64'h0);
        @(posedge clk);
        #1;
        check64("after_release_pc", pc, 64'h4);
        check64("after_release_pc4", pc_p4, 64'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
